// File: rtl/si570_pkg.sv
// Shared state encoding, Si570 register map constants and the default
// frequency preset table (six RFREQ/HS_DIV/N1 bytes for registers 7..12).
package si570_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FREEZE   = 3'd1,
        ST_LOAD     = 3'd2,
        ST_UNFREEZE = 3'd3,
        ST_NEWFREQ  = 3'd4,
        ST_SETTLE   = 3'd5
    } state_t;

    localparam logic [7:0] REG_RFREQ_BASE = 8'd7;
    localparam logic [7:0] REG_FREEZE     = 8'd137;
    localparam logic [7:0] REG_CTRL       = 8'd135;

    localparam logic [7:0] DATA_FREEZE    = 8'h10;
    localparam logic [7:0] DATA_UNFREEZE  = 8'h00;
    localparam logic [7:0] DATA_NEWFREQ   = 8'h40;

    localparam int PRESET_BYTES    = 6;
    localparam int PKG_NUM_PRESETS = 4;

    typedef logic [7:0] preset_row_t [PRESET_BYTES];
    typedef preset_row_t preset_table_t [PKG_NUM_PRESETS];

    // Byte 0 of each row goes to register 7, byte 5 to register 12.
    localparam preset_table_t PRESET_TABLE = '{
        '{8'h01, 8'hC2, 8'hBB, 8'hFB, 8'hE6, 8'h4C},
        '{8'h22, 8'h42, 8'hBC, 8'h01, 8'h1E, 8'hB8},
        '{8'hE0, 8'h03, 8'h02, 8'hB5, 8'hEA, 8'h58},
        '{8'hA1, 8'hC3, 8'h10, 8'h3E, 8'hA5, 8'h6D}
    };

endpackage

// File: rtl/si570_preset_rom.sv
// Combinational preset lookup: (preset index, byte select) -> register byte.
// Indices beyond the stored table wrap onto it; byte selects 6 and 7 read zero.
module si570_preset_rom
    import si570_pkg::*;
#(
    parameter int IW = 2
) (
    input  logic [IW-1:0] idx_i,
    input  logic [2:0]    byte_sel_i,
    output logic [7:0]    data_o
);

    localparam int RW = $clog2(PKG_NUM_PRESETS);

    logic [RW-1:0] row_s;

    // Table read with out-of-range byte guard.
    always_comb begin
        row_s  = RW'(int'(idx_i) % PKG_NUM_PRESETS);
        data_o = 8'h00;
        if (byte_sel_i < 3'd6) begin
            data_o = PRESET_TABLE[row_s][byte_sel_i];
        end else begin
            data_o = 8'h00;
        end
    end

endmodule

// File: rtl/si570_freq_sequencer.sv
// Si570 reprogramming sequencer: key event -> freeze, load regs 7..12, unfreeze,
// NewFreq, settle. Define SI570_EVT_QUEUE_EN to queue one key event while busy.
module si570_freq_sequencer
    import si570_pkg::*;
#(
    parameter int          NUM_PRESETS   = 4,
    parameter logic [6:0]  I2C_ADDR      = 7'h55,
    parameter logic [15:0] SETTLE_CYCLES = 16'd10000,
    localparam int         IW            = $clog2(NUM_PRESETS)
) (
    input  logic          iCLK,
    input  logic          iRST_n,
    input  logic          iKEY_EVT,
    output logic          oI2C_REQ,
    output logic [6:0]    oI2C_ADDR,
    output logic [7:0]    oI2C_REG,
    output logic [7:0]    oI2C_DATA,
    input  logic          iI2C_ACK,
    input  logic          iI2C_ERR,
    output logic          oBUSY,
    output logic          oDONE,
    output logic          oERROR,
    output logic [IW-1:0] oPRESET_IDX
);

    state_t        state_q, state_d;
    logic [2:0]    byte_q, byte_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [IW-1:0] pend_idx_q, pend_idx_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          req_q, req_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          start_s;
    logic [IW-1:0] next_idx_s;
    logic [7:0]    rom_byte_s;
    logic [7:0]    wr_reg_s;
    logic [7:0]    wr_data_s;

    si570_preset_rom #(.IW(IW)) u_rom (
        .idx_i      (pend_idx_q),
        .byte_sel_i (byte_q),
        .data_o     (rom_byte_s)
    );

`ifdef SI570_EVT_QUEUE_EN
    logic evt_pend_q, evt_pend_d;

    // One-deep event capture while busy; consumed when the FSM is back in IDLE.
    always_comb begin
        evt_pend_d = evt_pend_q;
        if (busy_q) begin
            evt_pend_d = evt_pend_q | iKEY_EVT;
        end else begin
            evt_pend_d = 1'b0;
        end
    end

    // Pending-event flag register.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            evt_pend_q <= 1'b0;
        end else begin
            evt_pend_q <= evt_pend_d;
        end
    end

    assign start_s = iKEY_EVT | evt_pend_q;
`else
    assign start_s = iKEY_EVT;
`endif

    assign next_idx_s = (idx_q == IW'(NUM_PRESETS - 1)) ? '0 : idx_q + IW'(1);

    // Register/data of the write belonging to the current state.
    always_comb begin
        wr_reg_s  = REG_FREEZE;
        wr_data_s = DATA_FREEZE;
        case (state_q)
            ST_LOAD: begin
                wr_reg_s  = REG_RFREQ_BASE + {5'd0, byte_q};
                wr_data_s = rom_byte_s;
            end
            ST_UNFREEZE: begin
                wr_reg_s  = REG_FREEZE;
                wr_data_s = DATA_UNFREEZE;
            end
            ST_NEWFREQ: begin
                wr_reg_s  = REG_CTRL;
                wr_data_s = DATA_NEWFREQ;
            end
            default: begin
                wr_reg_s  = REG_FREEZE;
                wr_data_s = DATA_FREEZE;
            end
        endcase
    end

    // Next-state and output computation.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        cnt_d      = cnt_q;
        pend_idx_d = pend_idx_q;
        idx_d      = idx_q;
        req_d      = req_q;
        reg_d      = reg_q;
        data_d     = data_q;
        done_d     = 1'b0;
        error_d    = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d    = ST_FREEZE;
                    pend_idx_d = next_idx_s;
                    error_d    = 1'b0;
                    byte_d     = 3'd0;
                    req_d      = 1'b1;
                    reg_d      = REG_FREEZE;
                    data_d     = DATA_FREEZE;
                end else begin
                    req_d = 1'b0;
                end
            end
            ST_FREEZE, ST_LOAD, ST_UNFREEZE, ST_NEWFREQ: begin
                // req_q low here is the one-cycle gap after an ack.
                if (!req_q) begin
                    req_d  = 1'b1;
                    reg_d  = wr_reg_s;
                    data_d = wr_data_s;
                end else if (iI2C_ERR) begin
                    req_d   = 1'b0;
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (iI2C_ACK) begin
                    req_d = 1'b0;
                    case (state_q)
                        ST_FREEZE: begin
                            state_d = ST_LOAD;
                            byte_d  = 3'd0;
                        end
                        ST_LOAD: begin
                            if (byte_q == 3'd5) begin
                                state_d = ST_UNFREEZE;
                            end else begin
                                byte_d = byte_q + 3'd1;
                            end
                        end
                        ST_UNFREEZE: begin
                            state_d = ST_NEWFREQ;
                        end
                        ST_NEWFREQ: begin
                            state_d = ST_SETTLE;
                            cnt_d   = SETTLE_CYCLES - 16'd1;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    done_d  = 1'b1;
                    idx_d   = pend_idx_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= ST_IDLE;
            byte_q     <= 3'd0;
            cnt_q      <= 16'd0;
            pend_idx_q <= '0;
            idx_q      <= '0;
            req_q      <= 1'b0;
            reg_q      <= 8'h00;
            data_q     <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            cnt_q      <= cnt_d;
            pend_idx_q <= pend_idx_d;
            idx_q      <= idx_d;
            req_q      <= req_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign oI2C_REQ    = req_q;
    assign oI2C_ADDR   = I2C_ADDR;
    assign oI2C_REG    = reg_q;
    assign oI2C_DATA   = data_q;
    assign oBUSY       = busy_q;
    assign oDONE       = done_q;
    assign oERROR      = error_q;
    assign oPRESET_IDX = idx_q;

endmodule

// File: tb/tb_si570_freq_sequencer.sv
// Self-checking bench for si570_freq_sequencer: table of whole-sequence
// scenarios with an in-bench I2C responder, plus hand-written reset corners.
module tb_si570_freq_sequencer;

    localparam int NP = 4;
    localparam int SC = 8;

    logic       iCLK = 1'b0;
    logic       iRST_n = 1'b0;
    logic       iKEY_EVT = 1'b0;
    logic       iI2C_ACK = 1'b0;
    logic       iI2C_ERR = 1'b0;
    logic       oI2C_REQ;
    logic [6:0] oI2C_ADDR;
    logic [7:0] oI2C_REG;
    logic [7:0] oI2C_DATA;
    logic       oBUSY;
    logic       oDONE;
    logic       oERROR;
    logic [1:0] oPRESET_IDX;

    si570_freq_sequencer #(
        .NUM_PRESETS   (NP),
        .I2C_ADDR      (7'h55),
        .SETTLE_CYCLES (16'd8)
    ) dut (
        .iCLK        (iCLK),
        .iRST_n      (iRST_n),
        .iKEY_EVT    (iKEY_EVT),
        .oI2C_REQ    (oI2C_REQ),
        .oI2C_ADDR   (oI2C_ADDR),
        .oI2C_REG    (oI2C_REG),
        .oI2C_DATA   (oI2C_DATA),
        .iI2C_ACK    (iI2C_ACK),
        .iI2C_ERR    (iI2C_ERR),
        .oBUSY       (oBUSY),
        .oDONE       (oDONE),
        .oERROR      (oERROR),
        .oPRESET_IDX (oPRESET_IDX)
    );

    always #5 iCLK = ~iCLK;

    localparam logic [7:0] PRE_TAB [4][6] = '{
        '{8'h01, 8'hC2, 8'hBB, 8'hFB, 8'hE6, 8'h4C},
        '{8'h22, 8'h42, 8'hBC, 8'h01, 8'h1E, 8'hB8},
        '{8'hE0, 8'h03, 8'h02, 8'hB5, 8'hEA, 8'h58},
        '{8'hA1, 8'hC3, 8'h10, 8'h3E, 8'hA5, 8'h6D}
    };

    typedef struct {
        int err_at;      // write number answered with ERR, -1 for none
        bit both;        // also raise ACK together with that ERR
        int extra_keys;  // key pulses injected mid-sequence
        int exp_writes;
        int exp_dones;
        int exp_idx;
        bit exp_error;
    } vec_t;

    vec_t vecs [9];
    int   checks = 0;
    int   failures = 0;
    int   cur_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_wr(input int preset, input int slot);
        case (slot)
            0:       return {8'd137, 8'h10};
            7:       return {8'd137, 8'h00};
            8:       return {8'd135, 8'h40};
            default: return {8'(6 + slot), PRE_TAB[preset][slot - 1]};
        endcase
    endfunction

    task automatic run_vec(input int vi);
        vec_t        v;
        int          wcnt = 0;
        int          dcnt = 0;
        int          last_ack = -100;
        int          kinj = 0;
        int          quiet = 0;
        int          cyc = 0;
        int          preset;
        bit          responded = 1'b0;
        bit          err_drv = 1'b0;
        bit          key_prev = 1'b0;
        logic [15:0] ew;
        v = vecs[vi];
        @(negedge iCLK);
        iKEY_EVT = 1'b1;
        @(negedge iCLK);
        iKEY_EVT = 1'b0;
        chk("start_req", 32'(oI2C_REQ), 32'd1);
        chk("start_busy", 32'(oBUSY), 32'd1);
        chk("start_error_cleared", 32'(oERROR), 32'd0);
        while (cyc < 400 && quiet < 4) begin
            iI2C_ACK = 1'b0;
            iI2C_ERR = 1'b0;
            iKEY_EVT = 1'b0;
            if (err_drv) begin
                chk("err_flag", 32'(oERROR), 32'd1);
                chk("err_busy_low", 32'(oBUSY), 32'd0);
                chk("err_no_done", 32'(oDONE), 32'd0);
                err_drv = 1'b0;
            end
            if (oDONE) begin
                dcnt++;
                chk("done_latency", 32'(cyc - last_ack), 32'(SC + 1));
                chk("done_busy_low", 32'(oBUSY), 32'd0);
            end
            if (responded) begin
                chk("req_gap", 32'(oI2C_REQ), 32'd0);
                responded = 1'b0;
            end else if (oI2C_REQ) begin
                preset = (cur_idx + 1 + wcnt / 9) % NP;
                ew = exp_wr(preset, wcnt % 9);
                chk("wr_reg", 32'(oI2C_REG), 32'(ew[15:8]));
                chk("wr_data", 32'(oI2C_DATA), 32'(ew[7:0]));
                if (wcnt == v.err_at) begin
                    iI2C_ERR = 1'b1;
                    iI2C_ACK = v.both;
                    err_drv = 1'b1;
                end else begin
                    iI2C_ACK = 1'b1;
                end
                wcnt++;
                responded = 1'b1;
                last_ack = cyc;
            end
            if (kinj < v.extra_keys && wcnt >= 2 && !key_prev) begin
                iKEY_EVT = 1'b1;
                kinj++;
            end
            key_prev = iKEY_EVT;
            quiet = (!oBUSY && !oI2C_REQ && !responded && !iKEY_EVT) ? quiet + 1 : 0;
            cyc++;
            @(negedge iCLK);
        end
        iI2C_ACK = 1'b0;
        iI2C_ERR = 1'b0;
        iKEY_EVT = 1'b0;
        if (quiet < 4) begin
            checks++;
            failures++;
            $display("FAIL vec%0d_timeout cycles=%0d quiet=%0d required_quiet=4", vi, cyc, quiet);
        end
        chk("writes", 32'(wcnt), 32'(v.exp_writes));
        chk("dones", 32'(dcnt), 32'(v.exp_dones));
        chk("preset_idx", 32'(oPRESET_IDX), 32'(v.exp_idx));
        chk("error_final", 32'(oERROR), 32'(v.exp_error));
        cur_idx = v.exp_idx;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(oI2C_REQ), 32'd0);
        chk({tag, "_reg"}, 32'(oI2C_REG), 32'd0);
        chk({tag, "_data"}, 32'(oI2C_DATA), 32'd0);
        chk({tag, "_busy"}, 32'(oBUSY), 32'd0);
        chk({tag, "_done"}, 32'(oDONE), 32'd0);
        chk({tag, "_error"}, 32'(oERROR), 32'd0);
        chk({tag, "_idx"}, 32'(oPRESET_IDX), 32'd0);
        chk({tag, "_addr"}, 32'(oI2C_ADDR), 32'h55);
    endtask

    initial begin
        int  seen;
        bit  resp;
        vecs[0] = '{-1, 1'b0, 0, 9, 1, 1, 1'b0};
        vecs[1] = '{-1, 1'b0, 0, 9, 1, 2, 1'b0};
        vecs[2] = '{-1, 1'b0, 0, 9, 1, 3, 1'b0};
        vecs[3] = '{-1, 1'b0, 0, 9, 1, 0, 1'b0};
        vecs[4] = '{ 2, 1'b0, 0, 3, 0, 0, 1'b1};
        vecs[5] = '{-1, 1'b0, 0, 9, 1, 1, 1'b0};
        vecs[6] = '{ 0, 1'b1, 0, 1, 0, 1, 1'b1};
`ifdef SI570_EVT_QUEUE_EN
        vecs[7] = '{-1, 1'b0, 2, 18, 2, 3, 1'b0};
`else
        vecs[7] = '{-1, 1'b0, 2, 9, 1, 2, 1'b0};
`endif
        vecs[8] = '{-1, 1'b0, 0, 9, 1, 1, 1'b0};

        repeat (3) @(negedge iCLK);
        chk_reset_vals("in_reset");
        iRST_n = 1'b1;
        @(negedge iCLK);
        chk_reset_vals("after_release");

        // Stray ACK/ERR with no request outstanding must be ignored.
        iI2C_ACK = 1'b1;
        iI2C_ERR = 1'b1;
        @(negedge iCLK);
        iI2C_ACK = 1'b0;
        iI2C_ERR = 1'b0;
        @(negedge iCLK);
        chk_reset_vals("stray_ack_err");

        cur_idx = 0;
        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // Reset while a LOAD write (reg 8) is outstanding.
        @(negedge iCLK);
        iKEY_EVT = 1'b1;
        @(negedge iCLK);
        iKEY_EVT = 1'b0;
        seen = 0;
        resp = 1'b0;
        for (int c = 0; c < 40; c++) begin
            iI2C_ACK = 1'b0;
            if (resp) begin
                resp = 1'b0;
            end else if (oI2C_REQ) begin
                seen++;
                if (seen == 3) break;
                iI2C_ACK = 1'b1;
                resp = 1'b1;
            end
            @(negedge iCLK);
        end
        iI2C_ACK = 1'b0;
        chk("rst_load_req", 32'(oI2C_REQ), 32'd1);
        chk("rst_load_reg", 32'(oI2C_REG), 32'd8);
        #2 iRST_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(negedge iCLK);
        iRST_n = 1'b1;
        cur_idx = 0;
        run_vec(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
